// File: rtl/uart_rx_word_packer_if.sv
// Byte-in / word-out bundle for uart_rx_word_packer, with status outputs.
// The slave modport is the packer itself; the master modport is its environment.
interface uart_rx_word_packer_if #(
  parameter int W_BYTE         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                             s_valid;
  logic [W_BYTE-1:0]                s_data;
  logic                             m_valid;
  logic                             m_ready;
  logic [W_BYTE*BYTES_PER_WORD-1:0] m_data;
  logic [LW-1:0]                    level;
  logic                             overflow;
  logic                             timeout_p;

  modport master (
    output s_valid, s_data, m_ready,
    input  m_valid, m_data, level, overflow, timeout_p
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output m_valid, m_data, level, overflow, timeout_p
  );
endinterface

// File: rtl/uart_rx_word_packer.sv
// Packs the uart_rx byte strobe stream into little-endian words, buffers them in a
// small FIFO behind a valid/ready port and drops stale partial words after an idle gap.
module uart_rx_word_packer #(
  parameter int W_BYTE         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rstn,
  uart_rx_word_packer_if.slave  bus
);
  localparam int WW = W_BYTE * BYTES_PER_WORD;
  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [CW-1:0] LAST_BYTE  = CW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic {IDLE, FILL} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  count, count_n;
  logic [TW-1:0]  timer, timer_n;
  logic [WW-1:0]  assembly, assembly_n;
  logic           push;
  logic           timeout_n;

  logic [WW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level;
  logic           overflow;
  logic           timeout_p;
  logic           pop;
  logic           push_ok;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      count    <= '0;
      timer    <= '0;
      assembly <= '0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      timer    <= timer_n;
      assembly <= assembly_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    count_n    = count;
    timer_n    = timer;
    assembly_n = assembly;
    push       = 1'b0;
    timeout_n  = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (bus.s_valid) begin
          assembly_n = {{(WW-W_BYTE){1'b0}}, bus.s_data};
          count_n    = CW'(1);
          state_n    = FILL;
        end
      end
      FILL: begin
        if (bus.s_valid) begin
          // A strobe on the expiry cycle still lands: the byte beats the timeout.
          timer_n = '0;
          assembly_n[int'(count)*W_BYTE +: W_BYTE] = bus.s_data;
          if (count == LAST_BYTE) begin
            push    = 1'b1;
            count_n = '0;
            state_n = IDLE;
          end else begin
            count_n = count + CW'(1);
          end
        end else if (timer == TIMER_LAST) begin
          timeout_n = 1'b1;
          timer_n   = '0;
          count_n   = '0;
          state_n   = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop     = (level != '0) && bus.m_ready;
  // A full FIFO still takes the word if the head leaves on the same edge.
  assign push_ok = push && ((level != FULL_LEVEL) || pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      timeout_p <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
      timeout_p <= timeout_n;
    end
  end

  // NOTE: word storage is not reset; stale entries are never visible because m_data is gated by level.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= assembly_n;
  end

  assign bus.m_valid   = (level != '0);
  assign bus.m_data    = bus.m_valid ? mem[rd_ptr] : '0;
  assign bus.level     = level;
  assign bus.overflow  = overflow;
  assign bus.timeout_p = timeout_p;
endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Randomised and directed bench for uart_rx_word_packer against a queue-based model.
module tb_uart_rx_word_packer;
  localparam int W_BYTE = 8;
  localparam int N      = 4;
  localparam int D      = 4;
  localparam int TO     = 50;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_rx_word_packer_if #(.W_BYTE(W_BYTE), .BYTES_PER_WORD(N), .FIFO_DEPTH(D)) bus ();

  uart_rx_word_packer #(
    .W_BYTE(W_BYTE), .BYTES_PER_WORD(N), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  part_q[$];
  logic [31:0] word_q[$];
  int          idle_cnt;
  bit          exp_ovf;
  bit          exp_to;
  int          to_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    part_q.delete();
    word_q.delete();
    idle_cnt = 0;
    exp_ovf  = 1'b0;
    exp_to   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] head;
    head = (word_q.size() != 0) ? word_q[0] : 32'h0;
    check({tag, ".valid"},    bus.m_valid,   word_q.size() != 0);
    check({tag, ".level"},    bus.level,     word_q.size());
    check({tag, ".data"},     bus.m_data,    head);
    check({tag, ".overflow"}, bus.overflow,  exp_ovf);
    check({tag, ".timeout"},  bus.timeout_p, exp_to);
  endtask

  // One clock: drive inputs, advance the model across the edge, compare after it.
  task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input string tag);
    logic [31:0] w;
    bit          to_next;
    to_next     = 1'b0;
    bus.s_valid = v;
    bus.s_data  = d;
    bus.m_ready = rdy;
    if (word_q.size() != 0 && rdy) void'(word_q.pop_front());
    if (v) begin
      part_q.push_back(d);
      idle_cnt = 0;
      if (part_q.size() == N) begin
        for (int i = 0; i < N; i++) w[i*8 +: 8] = part_q[i];
        part_q.delete();
        if (word_q.size() < D) word_q.push_back(w);
        else exp_ovf = 1'b1;
      end
    end else if (part_q.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == TO) begin
        part_q.delete();
        idle_cnt = 0;
        to_next  = 1'b1;
      end
    end
    exp_to = to_next;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
    if (bus.timeout_p) to_seen++;
  endtask

  task automatic send_word(input logic [31:0] w, input logic rdy, input string tag);
    for (int i = 0; i < N; i++) cycle(1'b1, w[i*8 +: 8], rdy, tag);
  endtask

  task automatic idle(input int n, input logic rdy, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy, tag);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #2 rstn = 1'b0;
    #1;
    check({tag, ".valid"},    bus.m_valid,   1'b0);
    check({tag, ".level"},    bus.level,     3'd0);
    check({tag, ".data"},     bus.m_data,    32'h0);
    check({tag, ".overflow"}, bus.overflow,  1'b0);
    check({tag, ".timeout"},  bus.timeout_p, 1'b0);
    model_clear();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int snap;
    int gap;
    int r;
    logic rdy;

    to_seen     = 0;
    rstn        = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    async_reset("reset");

    // Single word, consumer always ready.
    send_word(32'h44332211, 1'b1, "t1");
    check("t1.word", bus.m_data, 32'h44332211);
    idle(2, 1'b1, "t1.drain");
    check("t1.level0", bus.level, 3'd0);

    // Five words into a depth-4 FIFO with the consumer stalled.
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom), 1'b0, "t2");
    check("t2.full", bus.level, 3'd4);
    check("t2.ovf", bus.overflow, 1'b1);
    idle(6, 1'b1, "t2.drain");
    check("t2.empty", bus.level, 3'd0);

    // Stale partial word dropped, then clean resync.
    snap = to_seen;
    cycle(1'b1, 8'hAA, 1'b1, "t3");
    cycle(1'b1, 8'hBB, 1'b1, "t3");
    idle(TO + 2, 1'b1, "t3.gap");
    check("t3.pulses", to_seen - snap, 1);
    send_word(32'h04030201, 1'b1, "t3.next");
    check("t3.word", bus.m_data, 32'h04030201);
    idle(1, 1'b1, "t3.drain");

    // Byte strobe on the expiry cycle wins over the timeout.
    snap = to_seen;
    cycle(1'b1, 8'h10, 1'b1, "t4");
    idle(TO - 1, 1'b1, "t4.gap");
    cycle(1'b1, 8'h20, 1'b1, "t4.edge");
    cycle(1'b1, 8'h30, 1'b1, "t4");
    cycle(1'b1, 8'h40, 1'b1, "t4");
    check("t4.word", bus.m_data, 32'h40302010);
    check("t4.pulses", to_seen - snap, 0);
    idle(1, 1'b1, "t4.drain");

    // Full FIFO, final byte coincides with a pop.
    async_reset("t5.reset");
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0, "t5.fill");
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, "t5.part");
    cycle(1'b1, 8'h5A, 1'b1, "t5.pushpop");
    check("t5.level", bus.level, 3'd4);
    check("t5.ovf", bus.overflow, 1'b0);
    idle(5, 1'b1, "t5.drain");

    // Reset mid-word with two words buffered.
    send_word(32'hDEADBEEF, 1'b0, "t6");
    send_word(32'hCAFEF00D, 1'b0, "t6");
    cycle(1'b1, 8'h77, 1'b0, "t6");
    cycle(1'b1, 8'h88, 1'b0, "t6");
    async_reset("t6.reset");
    send_word(32'hA4A3A2A1, 1'b0, "t6.after");
    check("t6.level", bus.level, 3'd1);
    check("t6.word", bus.m_data, 32'hA4A3A2A1);
    idle(2, 1'b1, "t6.drain");

    // Random traffic: short, medium and timeout-length gaps, bursty consumer.
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      rdy = ((c / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      if (gap > 0) begin
        gap--;
        cycle(1'b0, 8'($urandom), rdy, "rand");
      end else begin
        cycle(1'b1, 8'($urandom), rdy, "rand");
        r = $urandom_range(0, 19);
        if (r < 14)      gap = $urandom_range(0, 2);
        else if (r < 18) gap = $urandom_range(3, 20);
        else             gap = $urandom_range(TO - 3, TO + 3);
      end
    end
    idle(8, 1'b1, "rand.drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
